// File: rtl/split_router.sv
// split_router: multicast fork router. One selected input port feeds a FWFT
// FIFO; the head flit is offered on every port set in output_mask and popped
// only after each masked branch has accepted it once.
//
// Parameters
//   input_sel   [0:4] one-hot source port ([0]-local [1]-west [2]-east
//                     [3]-north [4]-south); lowest set index wins, 0 if none
//   output_mask [0:4] destination ports; all-zero drains flits to nowhere
//   FIFO_DEPTH        input buffer depth, power of two >= 2
//
// Ports
//   clk, rstn          rising-edge clock, asynchronous active-low reset
//   data_i/valid_i     per-port input flit/valid (only input_sel is used)
//   ready_o            per-port input ready (only input_sel can be 1)
//   data_o/valid_o     per-port output flit/valid
//   ready_i            per-port downstream ready (unmasked ports ignored)
//
// Build option
//   DATA_PATH_EN defined   : FIFO stores flit data, data_o carries it.
//   DATA_PATH_EN undefined : FIFO tracks occupancy only, data_o is all zero;
//                            handshake timing is unchanged.
`ifndef DW
`define DW 32
`endif

module split_router #(
  parameter logic [0:4]  input_sel   = 5'b0,
  parameter logic [0:4]  output_mask = 5'b0,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [`DW-1:0] data_i  [0:4],
  input  logic [0:4]     valid_i,
  output logic [0:4]     ready_o,
  output logic [`DW-1:0] data_o  [0:4],
  output logic [0:4]     valid_o,
  input  logic [0:4]     ready_i
);

  function automatic int unsigned src_index(input logic [0:4] sel);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 5; i > 0; i--) begin
      if (sel[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned SRC = src_index(input_sel);

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [0:4]      sent_q, sent_d;
  logic            empty, full;
  logic            wr_en, done;
  logic [0:4]      fire;
  logic [`DW-1:0]  head;
  logic            unused_in;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  end

  // ready comes from the registered full flag only, so a pop in the same
  // cycle never opens a slot for a write.
  always_comb begin
    ready_o      = '0;
    ready_o[SRC] = ~full;
    wr_en        = valid_i[SRC] & ~full;
  end

  // valid depends on registered state only; ready_i just decides who fires.
  always_comb begin
    valid_o = empty ? '0 : (output_mask & ~sent_q);
    fire    = valid_o & ready_i;
    done    = ~empty && (((sent_q | fire) & output_mask) == output_mask);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(done);
    sent_d   = done ? '0 : (sent_q | fire);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sent_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sent_q   <= sent_d;
    end
  end

`ifdef DATA_PATH_EN
  logic [`DW-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i[SRC];
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];
`else
  assign head = '0;
`endif

  // Gated with ~empty so stale RAM contents never leak out after reset.
  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      data_o[i] = (output_mask[i] && !empty) ? head : '0;
    end
  end

  // Inputs of non-selected and unmasked ports are intentionally ignored.
  always_comb begin
    unused_in = ^valid_i ^ ^ready_i;
    for (int unsigned i = 0; i < 5; i++) begin
      unused_in = unused_in ^ (^data_i[i]);
    end
  end

endmodule
